// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int TIMEOUT_W = 12;

  // Round-robin pointer advance, wrapping at the requester count.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    int unsigned r;
    r = p + 1;
    if (r >= n) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         pick,
  output logic                     any
);

  int idx;

  // Scan upward from ptr; the first hit wins and blocks later candidates.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of a byte UART serializer.
// A source owns the transmitter from grant until its last byte or until it
// stalls for TIMEOUT cycles; a one-entry output register feeds the serializer.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_pulse
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 out_full_q, out_full_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 pulse_q, pulse_d;

  logic [N_REQ-1:0]     pick;
  logic                 any;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     g_next;
  logic                 g_valid, g_last, g_ready, accept;
  logic [7:0]           g_data;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign g_next = PTR_W'(ptr_inc(32'(gidx_q), N_REQ));

  // Encode the one-hot pick and select the granted source's byte stream.
  always_comb begin
    pick_idx = '0;
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
      if (gidx_q == PTR_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  // The owner may push whenever the output register is empty or draining this cycle.
  always_comb begin
    g_ready   = (state_q == LOCK) && (!out_full_q || tx_ready);
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx_q == PTR_W'(i)) req_ready[i] = g_ready;
    end
    accept = g_ready && g_valid;
  end

  // Next-state logic for the FSM, output register and stall counter.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    out_full_d = out_full_q;
    out_data_d = out_data_q;

    if (accept) begin
      out_full_d = 1'b1;
      out_data_d = g_data;
    end else if (tx_ready) begin
      out_full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any) begin
          state_d = LOCK;
          grant_d = pick;
          gidx_d  = pick_idx;
        end
      end
      LOCK: begin
        if (accept) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = g_next;
          end
        end else if (g_ready && !g_valid) begin
          // Only owner starvation counts; serializer back-pressure never does.
          cnt_d = cnt_q + 1'b1;
          if (TO_EN && (cnt_d == TO_LIM)) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = g_next;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      out_full_q <= 1'b0;
      out_data_q <= 8'h00;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      out_full_q <= out_full_d;
      out_data_q <= out_data_d;
      pulse_q    <= pulse_d;
    end
  end

  assign tx_valid      = out_full_q;
  assign tx_data       = out_data_q;
  assign grant         = grant_q;
  assign busy          = (state_q == LOCK) || out_full_q;
  assign timeout_pulse = pulse_q;

endmodule
